ahb2mem: RTL and testbench
==========================

AHB2MEM -- requirements
Module: ahb2mem

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; memory depth is 2^ADDR_W x 32 bits.
REQ-002 Parameter WAIT, default 1, data-phase wait states per transfer; legal range 0..7.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 HSEL  input  1  slave select from the address decoder.
REQ-006 HREADY  input  1  bus ready, the muxed HREADYOUT returned to all slaves.
REQ-007 HADDR  input  32  byte address.
REQ-008 HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 HWRITE  input  1  1 = write, 0 = read.
REQ-010 HSIZE  input  3  000 byte, 001 halfword, 010 word.
REQ-011 HWDATA  input  32  write data, valid during the data phase.
REQ-012 HREADYOUT  output  1  slave ready; low stalls the data phase.
REQ-013 HRDATA  output  32  read data, valid when HREADYOUT = 1 in a read data phase.

Function
REQ-014 Address phase accepted only when HSEL = 1, HREADY = 1 and HTRANS[1] = 1.
REQ-015 On acceptance, register word index HADDR[ADDR_W+1:2], byte offset HADDR[1:0], HSIZE and HWRITE; discard HADDR bits above ADDR_W+1, so addresses alias modulo 2^(ADDR_W+2).
REQ-016 IDLE/BUSY transfers, or HSEL = 0, start no data phase; HREADYOUT stays 1.
REQ-017 FSM states: IDLE (no data phase pending), WAITING (wait counter > 0), LAST (final data-phase cycle).
REQ-018 Acceptance with WAIT > 0: go to WAITING, wait counter = WAIT, HREADYOUT = 0.
REQ-019 Acceptance with WAIT = 0: go directly to LAST.
REQ-020 In WAITING, decrement the counter each cycle; on reaching 0, go to LAST. HREADYOUT = 0 for exactly WAIT cycles.
REQ-021 In LAST, HREADYOUT = 1.
REQ-022 In LAST, a write commits HWDATA to memory at the end of the cycle, using byte enables.
REQ-023 Write byte enables:
- HSIZE 000: lane = offset.
- HSIZE 001: lanes {offset[1],0} and {offset[1],1}.
- HSIZE 010: all four lanes.
- Any other HSIZE: no lanes; the write is dropped.
REQ-024 Read data: HRDATA = full 32-bit word mem[index] during a read LAST cycle; HRDATA = 0 otherwise. Unaligned or narrow reads return the whole word.
REQ-025 Back-to-back transfers: a new address phase accepted in a LAST cycle starts its data phase the next cycle with no idle gap. Without a new acceptance, return to IDLE.
REQ-026 Read after write: a read whose data phase directly follows a write's LAST cycle to the same word returns the newly written value.
REQ-027 Address phases presented while HREADYOUT = 0 are ignored; the master holds them under HREADY = 0.
REQ-028 Throughput: one transfer per WAIT+1 cycles, sustained.

Reset
REQ-029 Rst = 1 at a clock edge forces IDLE, wait counter = 0, HREADYOUT = 1, HRDATA = 0, and clears all captured address-phase state.
REQ-030 Rst asserted mid data phase aborts the transfer; a pending write is not committed.
REQ-031 Memory contents are not cleared by reset; their initial contents are undefined.
REQ-032 The first address phase may be accepted in the first cycle after Rst deasserts.

Verification
REQ-033 WAIT=1: word write 0xDEADBEEF to 0x04, then word read 0x04 -> HREADYOUT low 1 cycle per transfer; HRDATA = 0xDEADBEEF in the read LAST cycle.
REQ-034 Byte write 0xAA to 0x07 over word 0x11223344 at 0x04 -> subsequent read of 0x04 = 0xAA223344.
REQ-035 Halfword write 0x5566 to 0x0A over 0x00000000 -> read of 0x08 = 0x55660000. HSIZE=011 write to the same word leaves it unchanged.
REQ-036 WAIT=0: back-to-back NONSEQ write 0x1 to 0x10, then read 0x10 -> HREADYOUT constantly 1; read returns 0x00000001.
REQ-037 Aliasing and filtering: ADDR_W=8, write 0x12345678 to 0x400 -> read of 0x000 returns 0x12345678. HTRANS=01 or HSEL=0 transfers produce no memory change and no HREADYOUT drop.
REQ-038 Reset abort: WAIT=3, Rst pulsed during the second wait cycle of a write -> HREADYOUT = 1 next cycle; the target word keeps its old value.

Source files
------------

// File: rtl/ahb2mem.sv
// AHB-Lite slave wrapping a 2^ADDR_W x 32-bit memory with a fixed number of
// data-phase wait states. Byte/halfword writes use lane enables; reads return the whole word.
module ahb2mem #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    LAST    = 2'd2
  } stateT;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT);
  localparam int         DEPTH     = 1 << ADDR_W;

  stateT             state;
  logic [2:0]        waitCnt;
  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        byteOff;
  logic [2:0]        sizeReg;
  logic              writeReg;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic [3:0]        laneEn;
  logic              unusedBits;

  function automatic logic [3:0] byteLanes(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (size)
      3'b000:  lanes = 4'b0001 << off;
      3'b001:  lanes = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

  // HREADYOUT gating keeps held address phases from being taken during wait states.
  assign accept     = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign laneEn     = byteLanes(sizeReg, byteOff);
  assign unusedBits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      waitCnt   <= 3'd0;
      HREADYOUT <= 1'b1;
      wordIdx   <= '0;
      byteOff   <= 2'd0;
      sizeReg   <= 3'd0;
      writeReg  <= 1'b0;
    end else if (accept) begin
      wordIdx  <= HADDR[ADDR_W+1:2];
      byteOff  <= HADDR[1:0];
      sizeReg  <= HSIZE;
      writeReg <= HWRITE;
      if (WAIT == 0) begin
        state     <= LAST;
        waitCnt   <= 3'd0;
        HREADYOUT <= 1'b1;
      end else begin
        state     <= WAITING;
        waitCnt   <= WAIT_INIT;
        HREADYOUT <= 1'b0;
      end
    end else begin
      case (state)
        WAITING: begin
          if (waitCnt == 3'd1) begin
            state     <= LAST;
            waitCnt   <= 3'd0;
            HREADYOUT <= 1'b1;
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end
        default: begin
          state     <= IDLE;
          waitCnt   <= 3'd0;
          HREADYOUT <= 1'b1;
        end
      endcase
    end
  end

  // Commit at the end of LAST; a reset in that same cycle aborts the write.
  always_ff @(posedge Clk) begin
    if (!Rst && state == LAST && writeReg) begin
      for (int i = 0; i < 4; i++) begin
        if (laneEn[i]) mem[wordIdx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (state == LAST && !writeReg) HRDATA = mem[wordIdx];
  end

endmodule

// File: tb/tb_ahb2mem.sv
// Randomized bench for ahb2mem: three instances (WAIT=1, 0, 3) driven by a
// pipelined AHB master and checked against a word-array reference memory.
module tb_ahb2mem;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [1:0]  trans;
    bit          sel;
  } txnT;

  localparam int WAITS [3] = '{1, 0, 3};

  logic        Clk = 1'b0;
  logic        Rst;
  logic        hselBus;
  int          act;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  hro;
  logic [2:0][31:0] hrd;

  logic [31:0] refMem   [3][256];
  bit          refKnown [3][256];
  txnT         q[$];
  int          total = 0;
  int          bad = 0;

  always #5 Clk = ~Clk;

  ahb2mem #(.ADDR_W(8), .WAIT(1)) dut0 (
    .Clk(Clk), .Rst(Rst), .HSEL(hselBus && act == 0), .HREADY(hro[0]), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(hro[0]), .HRDATA(hrd[0])
  );
  ahb2mem #(.ADDR_W(8), .WAIT(0)) dut1 (
    .Clk(Clk), .Rst(Rst), .HSEL(hselBus && act == 1), .HREADY(hro[1]), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(hro[1]), .HRDATA(hrd[1])
  );
  ahb2mem #(.ADDR_W(8), .WAIT(3)) dut2 (
    .Clk(Clk), .Rst(Rst), .HSEL(hselBus && act == 2), .HREADY(hro[2]), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(hro[2]), .HRDATA(hrd[2])
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", tag, got, exp, act, $time);
    end
  endtask

  function automatic txnT mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data, input logic [1:0] trans = 2'b10,
                             input bit sel = 1'b1);
    txnT t;
    t.wr = wr; t.addr = addr; t.size = size; t.data = data; t.trans = trans; t.sel = sel;
    return t;
  endfunction

  function automatic txnT randTxn();
    txnT t;
    int  r;
    t.wr   = bit'($urandom_range(0, 1));
    t.addr = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    r      = int'($urandom_range(0, 9));
    t.size = (r < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
    t.data = $urandom;
    r      = int'($urandom_range(0, 9));
    t.trans = (r < 7) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    t.sel   = ($urandom_range(0, 9) != 0);
    return t;
  endfunction

  // Reference write: word index is the byte address modulo 1 KiB divided by four.
  task automatic modelWrite(input int k, input txnT t);
    int idx;
    int off;
    idx = int'(t.addr[9:2]);
    off = int'(t.addr[1:0]);
    case (t.size)
      3'd0: refMem[k][idx][8*off +: 8] = t.data[8*off +: 8];
      3'd1: if (off >= 2) refMem[k][idx][31:16] = t.data[31:16];
            else          refMem[k][idx][15:0]  = t.data[15:0];
      3'd2: begin
        refMem[k][idx]   = t.data;
        refKnown[k][idx] = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic driveAddr(input bit v, input txnT t);
    if (v) begin
      hselBus = t.sel; HTRANS = t.trans; HWRITE = t.wr; HSIZE = t.size; HADDR = t.addr;
    end else begin
      hselBus = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = 32'd0;
    end
  endtask

  // Pipelined master: next address is presented during the current data phase
  // and held while the slave stalls.
  task automatic runQ(input int k);
    txnT dp, ap;
    bit  dpV, apV;
    int  stalls, guard, idx;
    act = k;
    dpV = 1'b0; stalls = 0; guard = 0;
    apV = (q.size() > 0);
    if (apV) ap = q.pop_front();
    driveAddr(apV, ap);
    while ((dpV || apV) && guard < 3000) begin
      guard++;
      if (hro[k]) begin
        if (dpV) begin
          checkVal("stallCount", stalls, WAITS[k]);
          if (!dp.wr) begin
            idx = int'(dp.addr[9:2]);
            if (refKnown[k][idx]) checkVal("readData", hrd[k], refMem[k][idx]);
          end else begin
            checkVal("hrdataOnWrite", hrd[k], 32'd0);
            modelWrite(k, dp);
          end
        end else begin
          checkVal("hrdataIdle", hrd[k], 32'd0);
        end
        dpV = apV && ap.sel && ap.trans[1];
        dp = ap;
        stalls = 0;
        apV = (q.size() > 0);
        if (apV) ap = q.pop_front();
        @(posedge Clk); #1;
        driveAddr(apV, ap);
        HWDATA = (dpV && dp.wr) ? dp.data : $urandom;
      end else begin
        checkVal("spuriousStall", dpV, 1);
        checkVal("hrdataStall", hrd[k], 32'd0);
        stalls++;
        @(posedge Clk); #1;
      end
    end
    checkVal("queueDrained", dpV || apV, 0);
  endtask

  initial begin
    txnT  idleT;
    logic [31:0] old;
    idleT = mk(0, 0, 0, 0, 2'b00, 0);
    Rst = 1'b1; act = 0; HWDATA = 32'd0;
    driveAddr(0, idleT);
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 256; w++) refKnown[k][w] = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkVal("rstReady", hro[k], 1);
      checkVal("rstRdata", hrd[k], 32'd0);
    end

    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 8; w++) q.push_back(mk(1, 32'(w * 4), 3'd2, $urandom));
      q.push_back(mk(1, 32'h04, 3'd2, 32'hDEADBEEF));
      q.push_back(mk(0, 32'h04, 3'd2, 32'd0));
      q.push_back(mk(1, 32'h04, 3'd2, 32'h11223344));
      q.push_back(mk(1, 32'h07, 3'd0, 32'hAA000000));
      q.push_back(mk(0, 32'h04, 3'd2, 32'd0));
      q.push_back(mk(1, 32'h08, 3'd2, 32'h00000000));
      q.push_back(mk(1, 32'h0A, 3'd1, 32'h55660000));
      q.push_back(mk(0, 32'h08, 3'd2, 32'd0));
      q.push_back(mk(1, 32'h08, 3'd3, 32'hFFFFFFFF));
      q.push_back(mk(0, 32'h08, 3'd2, 32'd0));
      q.push_back(mk(1, 32'h10, 3'd2, 32'h00000001));
      q.push_back(mk(0, 32'h10, 3'd2, 32'd0));
      q.push_back(mk(1, 32'h400, 3'd2, 32'h12345678));
      q.push_back(mk(0, 32'h000, 3'd2, 32'd0));
      q.push_back(mk(1, 32'h000, 3'd2, 32'hCAFEF00D, 2'b01, 1));
      q.push_back(mk(1, 32'h000, 3'd2, 32'hCAFEF00D, 2'b10, 0));
      q.push_back(mk(1, 32'h000, 3'd2, 32'hCAFEF00D, 2'b00, 1));
      q.push_back(mk(0, 32'h000, 3'd2, 32'd0));
      for (int n = 0; n < 60; n++) q.push_back(randTxn());
      for (int w = 0; w < 8; w++) q.push_back(mk(0, 32'(w * 4), 3'd2, 32'd0));
      runQ(k);
    end

    // Reset during the second wait cycle of a WAIT=3 write must abort it.
    act = 2;
    old = refMem[2][5];
    hselBus = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h14;
    @(posedge Clk); #1;
    driveAddr(0, idleT);
    HWDATA = ~old;
    checkVal("abortWait1", hro[2], 0);
    @(posedge Clk); #1;
    checkVal("abortWait2", hro[2], 0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    checkVal("abortReady", hro[2], 1);
    checkVal("abortRdata", hrd[2], 32'd0);
    q.push_back(mk(0, 32'h14, 3'd2, 32'd0));
    runQ(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
